// File: rtl/grom_mem_arbiter_pkg.sv
// Shared types and constants for the ram_memory arbiter.
// Holds the default bus widths, the transaction FSM encoding and the port ids.
package grom_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int LOCK_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/grom_mem_arbiter_if.sv
// Requester and RAM-side signal bundle for grom_mem_arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface grom_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    // Handshake: a requester raises req with we/addr/wdata stable and keeps them
    // until its one-cycle ack; req is only looked at while the arbiter is idle,
    // rdata is valid with ack and holds until the next read on that port.
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_lock;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        input  mem_rdata,
        output a_ack, a_rdata, b_ack, b_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        output mem_rdata,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/grom_arb_pick.sv
// Winner selection: round-robin between A and B, with B allowed to keep the
// grant under b_lock for at most MAX_LOCK consecutive grants while A waits.
module grom_arb_pick
    import grom_pkg::*;
#(
    parameter int MAX_LOCK = 4
) (
    input  logic              a_req,
    input  logic              b_req,
    input  logic              b_lock,
    input  logic              grant_b,
    input  logic [LOCK_W-1:0] lock_cnt,
    output logic              win,
    output logic [LOCK_W-1:0] lock_cnt_nxt,
    output logic              grant_b_nxt
);

    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

    always_comb begin
        win = PORT_A;
        if (a_req && b_req) begin
            if (lock_cnt >= LOCK_MAX) begin
                win = PORT_A;
            end else if (b_lock && grant_b) begin
                win = PORT_B;
            end else begin
                win = grant_b ? PORT_A : PORT_B;
            end
        end else if (b_req) begin
            win = PORT_B;
        end
    end

    // The count only grows while B wins against a waiting A under lock.
    always_comb begin
        lock_cnt_nxt = '0;
        if ((win == PORT_B) && a_req && b_lock) begin
            lock_cnt_nxt = (lock_cnt >= LOCK_MAX) ? LOCK_MAX : lock_cnt + LOCK_W'(1);
        end
    end

    assign grant_b_nxt = win;

endmodule

// File: rtl/grom_mem_arbiter.sv
// Two-port arbiter in front of the single-port ram_memory: one 3-cycle
// transaction in flight (IDLE -> ACCESS -> RESP), ack pulsed to the winner.
module grom_mem_arbiter
    import grom_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    grom_mem_arbiter_if.slave  bus,
    output logic               busy,
    output logic               grant_b,
    output arb_state_t         dbg_state,
    output logic [LOCK_W-1:0]  dbg_lock_cnt
);

    arb_state_t        state_q, state_d;
    logic              grant_b_q, grant_b_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              op_we_q, op_we_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic              any_req;
    logic              pick_win;
    logic [LOCK_W-1:0] pick_lock_cnt;
    logic              pick_grant_b;

    assign any_req = bus.a_req | bus.b_req;

    grom_arb_pick #(
        .MAX_LOCK (MAX_LOCK)
    ) u_pick (
        .a_req        (bus.a_req),
        .b_req        (bus.b_req),
        .b_lock       (bus.b_lock),
        .grant_b      (grant_b_q),
        .lock_cnt     (lock_cnt_q),
        .win          (pick_win),
        .lock_cnt_nxt (pick_lock_cnt),
        .grant_b_nxt  (pick_grant_b)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mem_we defaults low, so the write strobe lasts only the ACCESS cycle.
    always_comb begin
        grant_b_d   = grant_b_q;
        lock_cnt_d  = lock_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        op_we_d     = op_we_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_b_d  = pick_grant_b;
                    lock_cnt_d = pick_lock_cnt;
                    if (pick_win == PORT_B) begin
                        mem_addr_d  = bus.b_addr;
                        mem_wdata_d = bus.b_wdata;
                        mem_we_d    = bus.b_we;
                        op_we_d     = bus.b_we;
                    end else begin
                        mem_addr_d  = bus.a_addr;
                        mem_wdata_d = bus.a_wdata;
                        mem_we_d    = bus.a_we;
                        op_we_d     = bus.a_we;
                    end
                end
            end
            RESP: begin
                if (grant_b_q == PORT_B) begin
                    b_ack_d = 1'b1;
                    if (!op_we_q) b_rdata_d = bus.mem_rdata;
                end else begin
                    a_ack_d = 1'b1;
                    if (!op_we_q) a_rdata_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_b_q   <= 1'b0;
            lock_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            op_we_q     <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            grant_b_q   <= grant_b_d;
            lock_cnt_q  <= lock_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            op_we_q     <= op_we_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign bus.a_ack     = a_ack_q;
    assign bus.b_ack     = b_ack_q;
    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;

    assign busy         = (state_q != IDLE);
    assign grant_b      = grant_b_q;
    assign dbg_state    = state_q;
    assign dbg_lock_cnt = lock_cnt_q;

endmodule

// File: tb/tb_grom_mem_arbiter.sv
// Bench for grom_mem_arbiter: transaction-level reference model with a RAM
// image, directed scenarios followed by random traffic from both ports.
module tb_grom_mem_arbiter;
    import grom_pkg::*;

    localparam int MAX_LOCK = 4;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
    } req_t;

    logic clk;
    logic reset_n;
    logic busy;
    logic grant_b;
    arb_state_t dbg_state;
    logic [LOCK_W-1:0] dbg_lock_cnt;

    grom_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    grom_mem_arbiter #(
        .ADDR_W   (12),
        .DATA_W   (8),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .busy         (busy),
        .grant_b      (grant_b),
        .dbg_state    (dbg_state),
        .dbg_lock_cnt (dbg_lock_cnt)
    );

    // ---------------- clock / reset / RAM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int we_cycles = 0;
    int a_ack_cyc[$];
    int b_ack_cyc[$];
    logic grant_log[$];
    logic [8:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:4095];
    int   m_ph;        // 0 waiting, 1 RAM cycle, 2 response cycle
    int   m_run;       // consecutive B wins over a waiting A under lock
    logic m_last_b;
    logic m_w, m_we;
    logic [11:0] m_addr;
    logic [7:0]  m_wdata;
    logic e_a_ack, e_b_ack, e_mem_we;
    logic [11:0] e_mem_addr;
    logic [7:0]  e_mem_wdata, e_a_rdata, e_b_rdata;

    task automatic model_reset();
        m_ph = 0; m_run = 0; m_last_b = 1'b0;
        m_w = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        e_a_ack = 1'b0; e_b_ack = 1'b0; e_mem_we = 1'b0;
        e_mem_addr = '0; e_mem_wdata = '0; e_a_rdata = '0; e_b_rdata = '0;
    endtask

    task automatic model_step();
        logic w;
        e_a_ack = 1'b0;
        e_b_ack = 1'b0;
        if (m_ph == 0) begin
            if (bus.a_req || bus.b_req) begin
                if (bus.a_req && bus.b_req) begin
                    if (m_run == MAX_LOCK)            w = 1'b0;
                    else if (bus.b_lock && m_last_b)  w = 1'b1;
                    else                              w = !m_last_b;
                end else begin
                    w = bus.b_req;
                end
                if (w && bus.a_req && bus.b_lock) m_run = (m_run < MAX_LOCK) ? m_run + 1 : MAX_LOCK;
                else m_run = 0;
                m_last_b = w;
                m_w = w;
                m_we    = w ? bus.b_we    : bus.a_we;
                m_addr  = w ? bus.b_addr  : bus.a_addr;
                m_wdata = w ? bus.b_wdata : bus.a_wdata;
                e_mem_we = m_we; e_mem_addr = m_addr; e_mem_wdata = m_wdata;
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            e_mem_we = 1'b0;
            if (m_we) ref_mem[m_addr] = m_wdata;
            m_ph = 2;
        end else begin
            if (!m_we) begin
                if (m_w) e_b_rdata = ref_mem[m_addr];
                else     e_a_rdata = ref_mem[m_addr];
            end
            if (m_w) e_b_ack = 1'b1; else e_a_ack = 1'b1;
            exp_q.push_back({m_w, m_w ? e_b_rdata : e_a_rdata});
            m_ph = 0;
        end
    endtask

    // ---------------- requester drivers ----------------
    req_t a_q[$];
    req_t b_q[$];
    logic a_act, b_act;

    task automatic drive_ports();
        req_t r;
        if (!a_act && a_q.size() > 0) begin
            r = a_q.pop_front();
            bus.a_req = 1'b1; bus.a_we = r.we; bus.a_addr = r.addr; bus.a_wdata = r.wdata;
            a_act = 1'b1;
        end else if (!a_act) begin
            bus.a_req = 1'b0;
        end
        if (!b_act && b_q.size() > 0) begin
            r = b_q.pop_front();
            bus.b_req = 1'b1; bus.b_we = r.we; bus.b_addr = r.addr; bus.b_wdata = r.wdata;
            b_act = 1'b1;
        end else if (!b_act) begin
            bus.b_req = 1'b0;
        end
    endtask

    task automatic push_req(input logic port_b, input logic we, input logic [11:0] addr, input logic [7:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        if (port_b) b_q.push_back(r); else a_q.push_back(r);
    endtask

    task automatic compare_all();
        logic [8:0] e;
        check_val("a_ack",     32'(bus.a_ack),     32'(e_a_ack));
        check_val("b_ack",     32'(bus.b_ack),     32'(e_b_ack));
        check_val("busy",      32'(busy),          32'(m_ph != 0));
        check_val("mem_we",    32'(bus.mem_we),    32'(e_mem_we));
        check_val("mem_addr",  32'(bus.mem_addr),  32'(e_mem_addr));
        check_val("mem_wdata", 32'(bus.mem_wdata), 32'(e_mem_wdata));
        check_val("grant_b",   32'(grant_b),       32'(m_last_b));
        check_val("lock_cnt",  32'(dbg_lock_cnt),  32'(m_run));
        check_val("a_rdata",   32'(bus.a_rdata),   32'(e_a_rdata));
        check_val("b_rdata",   32'(bus.b_rdata),   32'(e_b_rdata));
        if (bus.a_ack || bus.b_ack) begin
            if (exp_q.size() == 0) begin
                check_val("ack_unexpected", 32'({bus.a_ack, bus.b_ack}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("ack_port_data",
                          32'({bus.b_ack, bus.b_ack ? bus.b_rdata : bus.a_rdata}), 32'(e));
            end
        end
        if (bus.a_ack) a_ack_cyc.push_back(cyc);
        if (bus.b_ack) b_ack_cyc.push_back(cyc);
        if (bus.mem_we) we_cycles++;
        if (dbg_state == ACCESS) grant_log.push_back(grant_b);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset_n) model_step();
        @(negedge clk);
        compare_all();
        if (e_a_ack) a_act = 1'b0;
        if (e_b_ack) b_act = 1'b0;
        drive_ports();
    endtask

    task automatic clear_drivers();
        a_q.delete(); b_q.delete();
        a_act = 1'b0; b_act = 1'b0;
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int budget = 2000;
        while ((a_act || b_act || a_q.size() > 0 || b_q.size() > 0 || m_ph != 0) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            check_val("timeout_idle", 32'(m_ph), 32'd0);
            clear_drivers();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        clear_drivers();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic clear_logs();
        a_ack_cyc.delete(); b_ack_cyc.delete(); grant_log.delete();
        we_cycles = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        logic [9:0] lock_pat;
        reset_n = 1'b0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        bus.b_lock = 1'b0;
        a_act = 1'b0; b_act = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Preload addresses 0..16 through both ports.
        for (int i = 0; i <= 16; i++) begin
            push_req(i[0], 1'b1, 12'(i),
                     (i == 1) ? 8'h11 : (i == 2) ? 8'h22 : 8'($urandom_range(0, 255)));
        end
        drive_ports();
        wait_idle();

        // A-only write then read of 12'h010.
        clear_logs();
        c0 = cyc;
        push_req(1'b0, 1'b1, 12'h010, 8'h5A);
        drive_ports();
        wait_idle();
        check_val("t1_we_cycles", 32'(we_cycles), 32'd1);
        check_val("t1_ack_latency", 32'(a_ack_cyc.size() > 0 ? a_ack_cyc[0] - c0 : -1), 32'd3);
        push_req(1'b0, 1'b0, 12'h010, 8'h00);
        drive_ports();
        wait_idle();
        check_val("t1_rdata", 32'(bus.a_rdata), 32'h5A);
        check_val("t1_b_acks", 32'(b_ack_cyc.size()), 32'd0);

        // Simultaneous reads right after reset: B wins first (last grant was A).
        do_reset();
        clear_logs();
        c0 = cyc;
        push_req(1'b0, 1'b0, 12'h001, 8'h00);
        push_req(1'b1, 1'b0, 12'h002, 8'h00);
        drive_ports();
        wait_idle();
        check_val("t2_b_ack_cyc", 32'(b_ack_cyc.size() > 0 ? b_ack_cyc[0] - c0 : -1), 32'd3);
        check_val("t2_a_ack_cyc", 32'(a_ack_cyc.size() > 0 ? a_ack_cyc[0] - c0 : -1), 32'd6);
        check_val("t2_a_rdata", 32'(bus.a_rdata), 32'h11);
        check_val("t2_b_rdata", 32'(bus.b_rdata), 32'h22);

        // Lock burst: both ports requesting continuously with b_lock held.
        clear_logs();
        bus.b_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_req(1'b0, 1'b0, 12'(i), 8'h00);
            push_req(1'b1, 1'b0, 12'(i + 5), 8'h00);
        end
        drive_ports();
        wait_idle();
        bus.b_lock = 1'b0;
        lock_pat = 10'b1111011110;  // grant_b order, MSB first: B,B,B,B,A,B,B,B,B,A
        for (int i = 0; i < 10; i++) begin
            check_val("t3_grant_seq", 32'(i < grant_log.size() ? grant_log[i] : 1'bx), 32'(lock_pat[9 - i]));
        end

        // A request raised and dropped while a B transaction is in ACCESS.
        clear_logs();
        push_req(1'b1, 1'b0, 12'h003, 8'h00);
        drive_ports();
        tick();
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 12'h005; bus.a_wdata = 8'hFF;
        tick();
        wait_idle();
        check_val("t4_a_acks", 32'(a_ack_cyc.size()), 32'd0);
        check_val("t4_b_acks", 32'(b_ack_cyc.size()), 32'd1);

        // Reset during ACCESS of a B write, then re-issue.
        push_req(1'b1, 1'b1, 12'h020, 8'h77);
        drive_ports();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t5_mem_we_async", 32'(bus.mem_we), 32'd0);
        check_val("t5_busy_async", 32'(busy), 32'd0);
        check_val("t5_b_ack_async", 32'(bus.b_ack), 32'd0);
        model_reset();
        clear_drivers();
        repeat (2) tick();
        reset_n = 1'b1;
        clear_logs();
        push_req(1'b1, 1'b1, 12'h020, 8'h77);
        push_req(1'b0, 1'b0, 12'h020, 8'h00);
        drive_ports();
        wait_idle();
        check_val("t5_reissue_rdata", 32'(bus.a_rdata), 32'h77);
        check_val("t5_b_acks", 32'(b_ack_cyc.size()), 32'd1);

        // Back-to-back A reads 0..3.
        clear_logs();
        for (int i = 0; i < 4; i++) push_req(1'b0, 1'b0, 12'(i), 8'h00);
        drive_ports();
        wait_idle();
        check_val("t6_ack_count", 32'(a_ack_cyc.size()), 32'd4);
        for (int i = 1; i < 4; i++) begin
            check_val("t6_ack_spacing", 32'(i < a_ack_cyc.size() ? a_ack_cyc[i] - a_ack_cyc[i-1] : -1), 32'd3);
        end

        // Random traffic from both ports.
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) bus.b_lock = 1'($urandom_range(0, 1));
            if (a_q.size() < 2 && $urandom_range(0, 3) == 0)
                push_req(1'b0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 16)), 8'($urandom_range(0, 255)));
            if (b_q.size() < 2 && $urandom_range(0, 3) == 0)
                push_req(1'b1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 16)), 8'($urandom_range(0, 255)));
            tick();
        end
        wait_idle();
        tick();
        check_val("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
